shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_if.sv | 52 +++++
 rtl/shift_ctrl.sv | 115 +++++++++++
 tb/tb_shift_ctrl.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl_if
// Purpose  : Requester, shifter and response signals of shift_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface shift_ctrl_if #(
  parameter int AMT_W = 4
);
  logic             r0_valid;
  logic             r1_valid;
  logic             r0_ready;
  logic             r1_ready;
  logic [7:0]       r0_data;
  logic [7:0]       r1_data;
  logic [AMT_W-1:0] r0_amt;
  logic [AMT_W-1:0] r1_amt;
  logic             r0_left;
  logic             r1_left;

  logic [7:0]       sh_a;
  logic             sh_s2;
  logic             sh_s1;
  logic             sh_s0;
  logic             sh_left;
  logic [7:0]       sh_o;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [7:0]       rsp_data;
  logic             rsp_id;

  // master: requesters, external shifter and response consumer
  modport master (
    output r0_valid, r1_valid, r0_data, r1_data, r0_amt, r1_amt, r0_left, r1_left,
    input  r0_ready, r1_ready,
    input  sh_a, sh_s2, sh_s1, sh_s0, sh_left,
    output sh_o,
    input  rsp_valid, rsp_data, rsp_id,
    output rsp_ready
  );

  modport slave (
    input  r0_valid, r1_valid, r0_data, r1_data, r0_amt, r1_amt, r0_left, r1_left,
    output r0_ready, r1_ready,
    output sh_a, sh_s2, sh_s1, sh_s0, sh_left,
    input  sh_o,
    output rsp_valid, rsp_data, rsp_id,
    input  rsp_ready
  );
endinterface
`default_nettype wire

// File: rtl/shift_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : shift_ctrl
// Purpose  : Two-requester round-robin front end that chains passes through an
//            external 3-bit-amount shifter to reach any shift distance.
// Revision : 1.0 - initial release
// ============================================================================
module shift_ctrl #(
  parameter int AMT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       work, work_nx;
  logic [AMT_W-1:0] rem, rem_nx;
  logic             dir, dir_nx;
  logic             id, id_nx;
  logic             last_grant, last_grant_nx;

  logic             any_valid;
  logic             gnt;
  logic [2:0]       pass;
  logic [AMT_W-1:0] rem_after;

  assign any_valid = bus.r0_valid | bus.r1_valid;
  // On contention the requester that did not win last time gets the slot.
  assign gnt       = (bus.r0_valid & bus.r1_valid) ? ~last_grant : bus.r1_valid;
  assign pass      = (rem > AMT_W'(7)) ? 3'd7 : rem[2:0];
  assign rem_after = rem - AMT_W'(pass);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      work       <= '0;
      rem        <= '0;
      dir        <= 1'b0;
      id         <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_nx;
      work       <= work_nx;
      rem        <= rem_nx;
      dir        <= dir_nx;
      id         <= id_nx;
      last_grant <= last_grant_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    work_nx       = work;
    rem_nx        = rem;
    dir_nx        = dir;
    id_nx         = id;
    last_grant_nx = last_grant;
    bus.r0_ready  = 1'b0;
    bus.r1_ready  = 1'b0;
    bus.sh_a      = 8'h00;
    bus.sh_s2     = 1'b0;
    bus.sh_s1     = 1'b0;
    bus.sh_s0     = 1'b0;
    bus.sh_left   = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_data  = 8'h00;
    bus.rsp_id    = 1'b0;

    case (state)
      IDLE: begin
        bus.r0_ready = any_valid & ~gnt;
        bus.r1_ready = any_valid & gnt;
        if (any_valid) begin
          work_nx       = gnt ? bus.r1_data : bus.r0_data;
          rem_nx        = gnt ? bus.r1_amt  : bus.r0_amt;
          dir_nx        = gnt ? bus.r1_left : bus.r0_left;
          id_nx         = gnt;
          last_grant_nx = gnt;
          state_nx      = SHIFT;
        end
      end
      SHIFT: begin
        // A zero amount still takes one pass of 0 so every job visits SHIFT.
        bus.sh_a                          = work;
        {bus.sh_s2, bus.sh_s1, bus.sh_s0} = pass;
        bus.sh_left                       = dir;
        work_nx                           = bus.sh_o;
        rem_nx                            = rem_after;
        if (rem_after == '0) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = work;
        bus.rsp_id    = id;
        if (bus.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_shift_ctrl.sv
`default_nettype none
// Testbench for shift_ctrl: randomized requesters, queue-based scoreboard and
// a reference model computing results and pass schedules from shift arithmetic.
module tb_shift_ctrl;
  localparam int AMT_W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  shift_ctrl_if #(.AMT_W(AMT_W)) bus ();
  shift_ctrl #(.AMT_W(AMT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // External shifter: logical shift with zero fill.
  always_comb begin
    if (bus.sh_left) bus.sh_o = bus.sh_a << {bus.sh_s2, bus.sh_s1, bus.sh_s0};
    else             bus.sh_o = bus.sh_a >> {bus.sh_s2, bus.sh_s1, bus.sh_s0};
  end

  typedef struct {
    int data;
    int amt;
    bit left;
    bit id;
    int acc_edge;
  } job_t;

  job_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  bit   rr_on  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at cycle %0d", name, cyc);
  endtask

  function automatic int ref_shift(int d, int a, bit l);
    return l ? ((d << a) & 255) : (d >> a);
  endfunction

  function automatic int n_pass(int a);
    return (a == 0) ? 1 : (a + 6) / 7;
  endfunction

  function automatic int all_outs();
    return int'({bus.r0_ready, bus.r1_ready, bus.sh_a, bus.sh_s2, bus.sh_s1, bus.sh_s0,
                 bus.sh_left, bus.rsp_valid, bus.rsp_data, bus.rsp_id});
  endfunction

  task automatic set_req(int r, bit v, int d, int a, bit l);
    if (r == 0) begin
      bus.r0_valid = v; bus.r0_data = d[7:0]; bus.r0_amt = a[AMT_W-1:0]; bus.r0_left = l;
    end else begin
      bus.r1_valid = v; bus.r1_data = d[7:0]; bus.r1_amt = a[AMT_W-1:0]; bus.r1_left = l;
    end
  endtask

  // Present one job, push its expected result when accepted, then scramble inputs.
  task automatic send(int r, int d, int a, bit l);
    job_t j;
    bit   done;
    done = 1'b0;
    @(posedge clk); #1;
    set_req(r, 1'b1, d, a, l);
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if ((r == 0) ? bus.r0_ready : bus.r1_ready) begin
        j.data = ref_shift(d, a, l);
        j.amt = a;
        j.left = l;
        j.id = 1'(r);
        j.acc_edge = cyc + 1;
        q.push_back(j);
        done = 1'b1;
      end
    end
    if (!done) timeout($sformatf("accept_r%0d", r));
    @(posedge clk); #1;
    set_req(r, 1'b0, int'($urandom), int'($urandom), 1'($urandom));
  endtask

  task automatic drive(int r, int n, int maxgap);
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) @(posedge clk);
      send(r, int'($urandom_range(0, 255)), int'($urandom_range(0, (1 << AMT_W) - 1)),
           1'($urandom));
    end
  endtask

  // Monitor state: expected grant history and pass schedule of the job in flight.
  bit busy = 1'b0, shifting = 1'b0, seen_valid = 1'b0, last_g = 1'b1;
  int mrem = 0, mwork = 0, p = 0, eg = 0;
  bit v0, v1;

  always @(negedge clk) begin
    #1;
    if (rst) begin
      q.delete();
      busy = 1'b0; shifting = 1'b0; seen_valid = 1'b0; last_g = 1'b1;
    end else begin
      if (shifting && !bus.rsp_valid && q.size() != 0) begin
        p = (mrem > 7) ? 7 : mrem;
        chk("pass_amt", int'({bus.sh_s2, bus.sh_s1, bus.sh_s0}), p);
        chk("pass_a", int'(bus.sh_a), mwork);
        chk("pass_dir", int'(bus.sh_left), int'(q[0].left));
        mwork = ref_shift(mwork, p, q[0].left);
        mrem  = mrem - p;
      end else begin
        chk("sh_idle_zero", int'({bus.sh_a, bus.sh_s2, bus.sh_s1, bus.sh_s0, bus.sh_left}), 0);
      end

      if (!busy) begin
        v0 = bus.r0_valid;
        v1 = bus.r1_valid;
        eg = (v0 && v1) ? int'(!last_g) : (v1 ? 1 : 0);
        chk("ready0", int'(bus.r0_ready), int'((v0 || v1) && eg == 0));
        chk("ready1", int'(bus.r1_ready), int'((v0 || v1) && eg == 1));
        if ((v0 || v1) && q.size() != 0) begin
          busy = 1'b1; shifting = 1'b1; seen_valid = 1'b0; last_g = 1'(eg);
          mrem = q[$].amt;
          mwork = (eg == 0) ? int'(bus.r0_data) : int'(bus.r1_data);
        end
      end else begin
        chk("ready_busy", int'({bus.r0_ready, bus.r1_ready}), 0);
      end

      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          if (!seen_valid) begin
            chk("latency", cyc, q[0].acc_edge + n_pass(q[0].amt));
            seen_valid = 1'b1;
            shifting = 1'b0;
          end
          if (bus.rsp_ready) begin
            chk("rsp_data", int'(bus.rsp_data), q[0].data);
            chk("rsp_id", int'(bus.rsp_id), int'(q[0].id));
            void'(q.pop_front());
            busy = 1'b0;
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int i;
    i = 0;
    while ((busy || q.size() != 0) && i < 1000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 1000) timeout("drain");
  endtask

  int   bad;
  logic [7:0] hold_d;
  logic hold_id;

  initial begin
    set_req(0, 1'b0, 0, 0, 1'b0);
    set_req(1, 1'b0, 0, 0, 1'b0);
    bus.rsp_ready = 1'b1;
    #1 chk("reset_outs", all_outs(), 0);
    repeat (3) @(posedge clk);
    #1 chk("reset_outs_held", all_outs(), 0);
    rst = 1'b0;

    // Both requesters valid from reset: grants must alternate 0,1,0,1.
    fork
      drive(0, 4, 0);
      drive(1, 4, 0);
    join
    wait_idle();

    send(0, 'hFF, 3, 1'b1);
    wait_idle();
    send(1, 'hF0, 10, 1'b0);
    wait_idle();
    send(0, 'h5A, 0, 1'b1);
    wait_idle();
    send(1, 'h81, 7, 1'b0);
    wait_idle();
    send(0, 'h01, 8, 1'b1);
    wait_idle();

    // Stall the consumer: response must hold and no new job may be granted.
    bus.rsp_ready = 1'b0;
    send(0, 'h3C, 2, 1'b1);
    set_req(1, 1'b1, 'h11, 1, 1'b0);
    bad = 1;
    for (int i = 0; i < 50 && bad; i++) begin
      @(negedge clk); #2;
      if (bus.rsp_valid) bad = 0;
    end
    if (bad) timeout("hold_rsp");
    hold_d = bus.rsp_data;
    hold_id = bus.rsp_id;
    chk("hold_first_data", int'(hold_d), 'hF0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #2;
      chk("hold_stable", int'({bus.rsp_valid, bus.rsp_data, bus.rsp_id}),
          int'({1'b1, hold_d, hold_id}));
      chk("hold_no_ready", int'({bus.r0_ready, bus.r1_ready}), 0);
    end
    @(posedge clk); #1;
    set_req(1, 1'b0, 0, 0, 1'b0);
    bus.rsp_ready = 1'b1;
    wait_idle();

    // Reset during the second pass of a 15-bit shift aborts the job.
    send(0, 'hA5, 15, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1 chk("abort_outs", all_outs(), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #2;
      if (bus.rsp_valid) bad = 1;
    end
    chk("abort_no_rsp", bad, 0);
    send(1, 'h81, 1, 1'b0);
    wait_idle();

    // Randomized traffic with a randomly stalling consumer.
    rr_on = 1'b1;
    fork
      begin
        fork
          drive(0, 25, 3);
          drive(1, 25, 3);
        join
        rr_on = 1'b0;
      end
      begin
        while (rr_on) begin
          @(posedge clk); #1;
          bus.rsp_ready = 1'($urandom);
        end
      end
    join
    bus.rsp_ready = 1'b1;
    wait_idle();
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
